sram_stage_sequencer: RTL and testbench
=======================================

// Module: sram_stage_sequencer
// PURPOSE
//  Top-level sequencer that owns the single SRAM controller port. Runs NUM_STAGES processing stages
//  (UART load, decoder milestones, ...) in fixed order via enable/done handshakes. Muxes the active
//  stage's address, data and we_n onto the SRAM port; returns the port to the VGA reader when idle.
//  Optional per-stage inactivity timeout ends stages with no done signal, e.g. UART load.
// PARAMETERS
//  NUM_STAGES      4           number of sequenced stages, >=1
//  ADDR_W          18          SRAM address width
//  DATA_W          16          SRAM data width
//  TIMEOUT_CYCLES  50_000_000  inactivity cycles before a timeout-enabled stage is closed
//  TIMEOUT_MASK    4'b0001     bit k=1: stage k may end by timeout
// PORTS
//  Clock_50               in   1                  system clock
//  Reset                  in   1                  synchronous, active-high reset
//  Start                  in   1                  pulse; starts a sequence at stage 0 from S_IDLE
//  Stage_done             in   NUM_STAGES         bit k: stage k finished (level or pulse)
//  Stage_activity         in   NUM_STAGES         bit k: stage k made progress; restarts its timer
//  Stage_SRAM_address     in   NUM_STAGES*ADDR_W  packed, stage k at [k*ADDR_W +: ADDR_W]
//  Stage_SRAM_write_data  in   NUM_STAGES*DATA_W  packed, stage k at [k*DATA_W +: DATA_W]
//  Stage_SRAM_we_n        in   NUM_STAGES         per-stage write enable, active low
//  Idle_SRAM_address      in   ADDR_W             VGA reader address, used in S_IDLE
//  SRAM_address           out  ADDR_W             to SRAM controller
//  SRAM_write_data        out  DATA_W             to SRAM controller
//  SRAM_we_n              out  1                  to SRAM controller
//  Stage_enable           out  NUM_STAGES         one-hot level enable, registered
//  VGA_enable             out  1                  1 only in S_IDLE, registered
//  Current_stage          out  $clog2(NUM_STAGES)+1  active stage index, registered
//  Busy                   out  1                  1 outside S_IDLE
//  Timeout_flag           out  1                  sticky: last sequence had >=1 timeout-closed stage
// BEHAVIOUR
//  Reset values: Stage_enable=0, VGA_enable=1, Current_stage=0, Busy=0, Timeout_flag=0, state S_IDLE.
//  States:
//  - S_IDLE: SRAM_address=Idle_SRAM_address, we_n=1. On Start: Timeout_flag<=0, Current_stage<=0, ->S_HANDOFF.
//  - S_HANDOFF: exactly 1 cycle. Address/data from stage Current_stage, SRAM_we_n forced 1, enables all 0.
//    -> S_RUN; Stage_enable[Current_stage]<=1 in the same edge.
//  - S_RUN: all three SRAM outputs come combinationally from stage Current_stage.
//    Stage ends on Stage_done[cur], or on timeout if TIMEOUT_MASK[cur] is set.
//    On stage end: Stage_enable<=0. If last stage: ->S_IDLE, VGA_enable<=1. Else Current_stage++, ->S_HANDOFF.
//  Latency: Start at edge t -> Stage_enable[0]=1 after edge t+2. Stage_done at edge t -> next stage enabled after t+2.
//  VGA_enable<=0 on the Start edge.
//  Timeout (masked stage only):
//  - Timer is TO_W=$clog2(TIMEOUT_CYCLES) bits. Cleared on S_RUN entry and on any cycle with Stage_activity[cur]=1.
//    Otherwise it increments and saturates at TIMEOUT_CYCLES-1.
//  - seen_act is set by the first Stage_activity[cur] in the stage.
//  - Timeout fires when timer==TIMEOUT_CYCLES-1 && seen_act; then Timeout_flag<=1.
//    With no activity at all, the stage waits indefinitely (e.g. UART waiting for its first byte).
//  Boundaries:
//  - Stage_done and timeout in the same cycle: counts as done; Timeout_flag unchanged.
//  - Stage_done bits of non-active stages, and any done in S_IDLE/S_HANDOFF: ignored.
//  - Start outside S_IDLE: ignored. Stage_activity in the timer's clear cycle: wins, timer stays 0.
//  - NUM_STAGES=1: S_RUN end goes straight to S_IDLE.
//  - Reset mid-sequence: next edge returns all outputs to reset values; stage interrupted, no done required.
// CONFIGURATION
//  SEQ_AUTO_START_EN defined: first cycle after Reset deasserts acts as an internal Start pulse.
//  The sequence runs once at power-up without Start; later sequences still need Start.
//  Not defined: sequencing begins only on Start.
// TESTING  (NUM_STAGES=3, TIMEOUT_CYCLES=100, TIMEOUT_MASK=3'b001)
//  1. Reset then idle, Idle_SRAM_address=18'h23E00 -> SRAM_address=18'h23E00, we_n=1, VGA_enable=1, Busy=0.
//  2. Start at edge 10 -> edge 11 HANDOFF, we_n=1 even with Stage_SRAM_we_n[0]=0.
//     Edge 12 Stage_enable=3'b001, SRAM_address=stage-0 address.
//  3. Stage 0: activity pulses at cycles 20,30, then quiet -> timeout at cycle 30+100.
//     Then Timeout_flag=1 and Stage_enable=3'b010 two edges later.
//  4. Stage 0: no activity for 500 cycles -> stays in S_RUN, Stage_enable=3'b001, no timeout.
//  5. Stage_done[2] while stage 1 active: ignored. Stage_done[1] then Stage_done[2]: stage 2 runs,
//     then back to S_IDLE with VGA_enable=1 and Stage_enable=0.
//  6. Reset at cycle 5 of stage 1 -> next edge all outputs at reset values. Start at edge 20 restarts stage 0.
//     Also rerun case 1 with SEQ_AUTO_START_EN defined: Stage_enable[0]=1 two edges after reset release.

Source files
------------

// File: rtl/sram_stage_sequencer_if.sv
// Stage/SRAM bus between the sequencer and its processing stages.
// master: sequencer side (drives enables and the SRAM controller port).
// slave : stage side (drives per-stage done/activity and SRAM requests).
interface sram_stage_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16
);
  logic [NUM_STAGES-1:0]        Stage_done;
  logic [NUM_STAGES-1:0]        Stage_activity;
  logic [NUM_STAGES*ADDR_W-1:0] Stage_SRAM_address;
  logic [NUM_STAGES*DATA_W-1:0] Stage_SRAM_write_data;
  logic [NUM_STAGES-1:0]        Stage_SRAM_we_n;
  logic [NUM_STAGES-1:0]        Stage_enable;
  logic [ADDR_W-1:0]            SRAM_address;
  logic [DATA_W-1:0]            SRAM_write_data;
  logic                         SRAM_we_n;

  modport master (
    input  Stage_done, Stage_activity, Stage_SRAM_address, Stage_SRAM_write_data, Stage_SRAM_we_n,
    output Stage_enable, SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    output Stage_done, Stage_activity, Stage_SRAM_address, Stage_SRAM_write_data, Stage_SRAM_we_n,
    input  Stage_enable, SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/sram_stage_sequencer.sv
// Sequencer owning the single SRAM controller port. Runs NUM_STAGES stages in
// order through enable/done handshakes, muxes the active stage onto the SRAM
// port, and hands the port back to the VGA reader while idle. Stages flagged in
// TIMEOUT_MASK may also be closed after TIMEOUT_CYCLES of inactivity, but only
// once they have shown activity at least once.
// Optional build macro: SEQ_AUTO_START_EN -- the first cycle after Reset is
// released acts as an internal Start pulse (power-up sequence run).
module sram_stage_sequencer #(
  parameter int                     NUM_STAGES     = 4,
  parameter int                     ADDR_W         = 18,
  parameter int                     DATA_W         = 16,
  parameter int                     TIMEOUT_CYCLES = 50_000_000,
  parameter logic [NUM_STAGES-1:0]  TIMEOUT_MASK   = NUM_STAGES'(1),
  localparam int                    CS_W           = $clog2(NUM_STAGES) + 1
) (
  input  logic                  Clock_50,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_W-1:0]     Idle_SRAM_address,
  sram_stage_sequencer_if.master bus,
  output logic                  VGA_enable,
  output logic [CS_W-1:0]       Current_stage,
  output logic                  Busy,
  output logic                  Timeout_flag
);

  localparam int               TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CS_W-1:0]  LAST   = CS_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HANDOFF, S_RUN} state_t;

  state_t                state, nxt_state;
  logic [NUM_STAGES-1:0] en_q, nxt_en;
  logic                  vga_q, nxt_vga;
  logic [CS_W-1:0]       cur_q, nxt_cur;
  logic [TO_W-1:0]       timer_q, nxt_timer;
  logic                  seen_q, nxt_seen;
  logic                  flag_q, nxt_flag;

  logic                  start_int;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_data;
  logic                  sel_we_n, sel_done, sel_act, sel_mask;
  logic                  to_hit;

`ifdef SEQ_AUTO_START_EN
  logic rst_q;
  // Remember last cycle's reset so its falling edge can fire one internal Start
  always_ff @(posedge Clock_50) rst_q <= Reset;
  assign start_int = Start | (rst_q & ~Reset);
`else
  assign start_int = Start;
`endif

  // Pick out the active stage's request and handshake bits
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_we_n = 1'b1;
    sel_done = 1'b0;
    sel_act  = 1'b0;
    sel_mask = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (cur_q == CS_W'(k)) begin
        sel_addr = bus.Stage_SRAM_address[k*ADDR_W +: ADDR_W];
        sel_data = bus.Stage_SRAM_write_data[k*DATA_W +: DATA_W];
        sel_we_n = bus.Stage_SRAM_we_n[k];
        sel_done = bus.Stage_done[k];
        sel_act  = bus.Stage_activity[k];
        sel_mask = TIMEOUT_MASK[k];
      end
    end
  end

  // SRAM port mux; writes are suppressed during handoff so a stage can't write before it is enabled
  always_comb begin
    bus.SRAM_address    = Idle_SRAM_address;
    bus.SRAM_write_data = '0;
    bus.SRAM_we_n       = 1'b1;
    case (state)
      S_HANDOFF: begin
        bus.SRAM_address    = sel_addr;
        bus.SRAM_write_data = sel_data;
      end
      S_RUN: begin
        bus.SRAM_address    = sel_addr;
        bus.SRAM_write_data = sel_data;
        bus.SRAM_we_n       = sel_we_n;
      end
      default: ;
    endcase
  end

  // Timeout only after the stage has shown life; a silent stage waits forever
  assign to_hit = sel_mask & seen_q & (timer_q == TO_MAX);

  // Next-state and next-register values
  always_comb begin
    nxt_state = state;
    nxt_en    = en_q;
    nxt_vga   = vga_q;
    nxt_cur   = cur_q;
    nxt_timer = timer_q;
    nxt_seen  = seen_q;
    nxt_flag  = flag_q;
    case (state)
      S_IDLE: begin
        if (start_int) begin
          nxt_flag  = 1'b0;
          nxt_cur   = '0;
          nxt_vga   = 1'b0;
          nxt_state = S_HANDOFF;
        end
      end
      S_HANDOFF: begin
        for (int k = 0; k < NUM_STAGES; k++) nxt_en[k] = (cur_q == CS_W'(k));
        nxt_timer = '0;
        nxt_seen  = 1'b0;
        nxt_state = S_RUN;
      end
      S_RUN: begin
        if (sel_act) begin
          nxt_timer = '0;
          nxt_seen  = 1'b1;
        end else if (timer_q != TO_MAX) begin
          nxt_timer = timer_q + 1'b1;
        end
        if (sel_done || to_hit) begin
          nxt_en = '0;
          // A simultaneous done wins: the stage finished on its own
          if (!sel_done) nxt_flag = 1'b1;
          if (cur_q == LAST) begin
            nxt_vga   = 1'b1;
            nxt_state = S_IDLE;
          end else begin
            nxt_cur   = cur_q + 1'b1;
            nxt_state = S_HANDOFF;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state   <= S_IDLE;
      en_q    <= '0;
      vga_q   <= 1'b1;
      cur_q   <= '0;
      timer_q <= '0;
      seen_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      en_q    <= nxt_en;
      vga_q   <= nxt_vga;
      cur_q   <= nxt_cur;
      timer_q <= nxt_timer;
      seen_q  <= nxt_seen;
      flag_q  <= nxt_flag;
    end
  end

  assign bus.Stage_enable = en_q;
  assign VGA_enable       = vga_q;
  assign Current_stage    = cur_q;
  assign Busy             = (state != S_IDLE);
  assign Timeout_flag     = flag_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Bench for sram_stage_sequencer with 3 stages, 100-cycle timeout on stage 0.
// Expected enable transitions are queued when stimulus is applied and popped
// when the enable vector changes.
module tb_sram_stage_sequencer;
  localparam int NS = 3;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          Reset, Start;
  logic [AW-1:0] idle_addr;
  logic          VGA_enable, Busy, Timeout_flag;
  logic [2:0]    Current_stage;

  sram_stage_sequencer_if #(.NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW)) bus();

  sram_stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW),
    .TIMEOUT_CYCLES(100), .TIMEOUT_MASK(3'b001)
  ) dut (
    .Clock_50(clk), .Reset(Reset), .Start(Start), .Idle_SRAM_address(idle_addr),
    .bus(bus), .VGA_enable(VGA_enable), .Current_stage(Current_stage),
    .Busy(Busy), .Timeout_flag(Timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int lat; logic [2:0] en; logic flag; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] saddr [NS];
  logic [DW-1:0] sdata [NS];
  localparam logic [NS-1:0] SWE = 3'b010;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en_change(input int bound, output int n, output bit to);
    logic [2:0] prev;
    prev = bus.Stage_enable;
    n = 0;
    to = 1'b1;
    while (n < bound) begin
      tick();
      n++;
      if (bus.Stage_enable !== prev) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [AW+7:0] obs, exp;
    Reset = 1'b1; Start = 1'b0;
    bus.Stage_done = '0; bus.Stage_activity = '0;
    idle_addr = 18'h23E00;
    repeat (3) tick();
    obs = {bus.Stage_enable, VGA_enable, Busy, Timeout_flag, Current_stage[1:0]};
    checks++;
    if (obs[7:0] !== {3'b000, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      errors++; $display("FAIL reset_hold: got %b expected %b", obs[7:0], 8'b00010000);
    end
    Reset = 1'b0;
`ifdef SEQ_AUTO_START_EN
    tick(); tick();
    checks++;
    if (bus.Stage_enable !== 3'b001) begin
      errors++; $display("FAIL auto_start: en=%b expected 001", bus.Stage_enable);
    end
    for (int k = 0; k < NS; k++) begin
      bus.Stage_done = 3'(1 << k); tick(); bus.Stage_done = '0; tick();
    end
`endif
    tick();
    obs = {bus.SRAM_address, bus.SRAM_we_n, VGA_enable, Busy, bus.Stage_enable, Timeout_flag};
    exp = {18'h23E00, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0};
    checks++;
    if (obs !== exp || Current_stage !== 3'd0) begin
      errors++; $display("FAIL reset_idle: got %h cur=%0d expected %h cur=0", obs, Current_stage, exp);
    end
  endtask

  task automatic test_start_handoff();
    exp_t e;
    exp_q.push_back(exp_t'{2, 3'b001, 1'b0});
    Start = 1'b1; tick(); Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || VGA_enable !== 1'b0 || bus.Stage_enable !== 3'b000 || bus.SRAM_we_n !== 1'b1 ||
        bus.SRAM_address !== saddr[0] || bus.SRAM_write_data !== sdata[0]) begin
      errors++; $display("FAIL handoff: busy=%b vga=%b en=%b we_n=%b addr=%h data=%h expected 1 0 000 1 %h %h",
        Busy, VGA_enable, bus.Stage_enable, bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data, saddr[0], sdata[0]);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.Stage_enable !== e.en || Timeout_flag !== e.flag) begin
      errors++; $display("FAIL run_entry: en=%b flag=%b expected en=%b flag=%b", bus.Stage_enable, Timeout_flag, e.en, e.flag);
    end
    checks++;
    if (bus.SRAM_we_n !== 1'b0 || bus.SRAM_address !== saddr[0]) begin
      errors++; $display("FAIL run_mux0: we_n=%b addr=%h expected 0 %h", bus.SRAM_we_n, bus.SRAM_address, saddr[0]);
    end
  endtask

  task automatic test_no_activity();
    repeat (500) tick();
    checks++;
    if (bus.Stage_enable !== 3'b001 || Busy !== 1'b1 || Timeout_flag !== 1'b0 || Current_stage !== 3'd0) begin
      errors++; $display("FAIL no_activity: en=%b busy=%b flag=%b cur=%0d expected 001 1 0 0",
        bus.Stage_enable, Busy, Timeout_flag, Current_stage);
    end
  endtask

  task automatic test_timeout();
    exp_t e; int n; bit to;
    bus.Stage_activity = 3'b001; tick(); bus.Stage_activity = '0;
    repeat (9) tick();
    bus.Stage_activity = 3'b001; tick(); bus.Stage_activity = '0;
    exp_q.push_back(exp_t'{100, 3'b000, 1'b1});
    exp_q.push_back(exp_t'{1, 3'b010, 1'b1});
    for (int i = 0; i < 2; i++) begin
      wait_en_change(200, n, to);
      e = exp_q.pop_front();
      checks++;
      if (to || n != e.lat || bus.Stage_enable !== e.en || Timeout_flag !== e.flag) begin
        errors++; $display("FAIL timeout_%0d: to=%0d lat=%0d en=%b flag=%b expected lat=%0d en=%b flag=%b",
          i, to, n, bus.Stage_enable, Timeout_flag, e.lat, e.en, e.flag);
      end
    end
  endtask

  task automatic test_stage_sequence();
    exp_t e; int n; bit to;
    checks++;
    if (Current_stage !== 3'd1 || bus.SRAM_address !== saddr[1] || bus.SRAM_write_data !== sdata[1] || bus.SRAM_we_n !== 1'b1) begin
      errors++; $display("FAIL mux1: cur=%0d addr=%h data=%h we_n=%b expected 1 %h %h 1",
        Current_stage, bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n, saddr[1], sdata[1]);
    end
    bus.Stage_done = 3'b101; Start = 1'b1;
    repeat (5) tick();
    bus.Stage_done = '0; Start = 1'b0;
    checks++;
    if (bus.Stage_enable !== 3'b010 || Current_stage !== 3'd1 || Timeout_flag !== 1'b1) begin
      errors++; $display("FAIL ignored_done: en=%b cur=%0d flag=%b expected 010 1 1", bus.Stage_enable, Current_stage, Timeout_flag);
    end
    exp_q.push_back(exp_t'{1, 3'b000, 1'b1});
    exp_q.push_back(exp_t'{1, 3'b100, 1'b1});
    bus.Stage_done = 3'b010;
    for (int i = 0; i < 2; i++) begin
      wait_en_change(10, n, to);
      bus.Stage_done = '0;
      e = exp_q.pop_front();
      checks++;
      if (to || n != e.lat || bus.Stage_enable !== e.en || Timeout_flag !== e.flag) begin
        errors++; $display("FAIL done1_%0d: to=%0d lat=%0d en=%b flag=%b expected lat=%0d en=%b flag=%b",
          i, to, n, bus.Stage_enable, Timeout_flag, e.lat, e.en, e.flag);
      end
    end
    checks++;
    if (Current_stage !== 3'd2 || bus.SRAM_address !== saddr[2] || bus.SRAM_we_n !== 1'b0) begin
      errors++; $display("FAIL mux2: cur=%0d addr=%h we_n=%b expected 2 %h 0", Current_stage, bus.SRAM_address, bus.SRAM_we_n, saddr[2]);
    end
    exp_q.push_back(exp_t'{1, 3'b000, 1'b1});
    bus.Stage_done = 3'b100;
    wait_en_change(10, n, to);
    bus.Stage_done = '0;
    e = exp_q.pop_front();
    checks++;
    if (to || n != e.lat || bus.Stage_enable !== e.en || Timeout_flag !== e.flag) begin
      errors++; $display("FAIL done2: to=%0d lat=%0d en=%b flag=%b expected lat=%0d en=%b flag=%b",
        to, n, bus.Stage_enable, Timeout_flag, e.lat, e.en, e.flag);
    end
    checks++;
    if (VGA_enable !== 1'b1 || Busy !== 1'b0 || bus.SRAM_address !== idle_addr || bus.SRAM_we_n !== 1'b1) begin
      errors++; $display("FAIL back_to_idle: vga=%b busy=%b addr=%h we_n=%b expected 1 0 %h 1",
        VGA_enable, Busy, bus.SRAM_address, bus.SRAM_we_n, idle_addr);
    end
  endtask

  task automatic test_done_and_timeout();
    exp_t e; int n; bit to;
    exp_q.push_back(exp_t'{2, 3'b001, 1'b0});
    Start = 1'b1;
    wait_en_change(10, n, to);
    Start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (to || n != e.lat || bus.Stage_enable !== e.en || Timeout_flag !== e.flag) begin
      errors++; $display("FAIL restart2: to=%0d lat=%0d en=%b flag=%b expected lat=%0d en=%b flag=%b",
        to, n, bus.Stage_enable, Timeout_flag, e.lat, e.en, e.flag);
    end
    bus.Stage_activity = 3'b001; tick(); bus.Stage_activity = '0;
    repeat (99) tick();
    checks++;
    if (bus.Stage_enable !== 3'b001) begin
      errors++; $display("FAIL pre_timeout: en=%b expected 001", bus.Stage_enable);
    end
    exp_q.push_back(exp_t'{1, 3'b000, 1'b0});
    bus.Stage_done = 3'b001; tick(); bus.Stage_done = '0;
    e = exp_q.pop_front();
    checks++;
    if (bus.Stage_enable !== e.en || Timeout_flag !== e.flag) begin
      errors++; $display("FAIL done_vs_timeout: en=%b flag=%b expected en=%b flag=%b", bus.Stage_enable, Timeout_flag, e.en, e.flag);
    end
    tick();
    checks++;
    if (bus.Stage_enable !== 3'b010 || Current_stage !== 3'd1) begin
      errors++; $display("FAIL stage1_after: en=%b cur=%0d expected 010 1", bus.Stage_enable, Current_stage);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int n; bit to;
    repeat (5) tick();
    Reset = 1'b1; tick();
    checks++;
    if (bus.Stage_enable !== 3'b000 || VGA_enable !== 1'b1 || Current_stage !== 3'd0 || Busy !== 1'b0 ||
        Timeout_flag !== 1'b0 || bus.SRAM_address !== idle_addr || bus.SRAM_we_n !== 1'b1) begin
      errors++; $display("FAIL reset_mid: en=%b vga=%b cur=%0d busy=%b flag=%b addr=%h expected 000 1 0 0 0 %h",
        bus.Stage_enable, VGA_enable, Current_stage, Busy, Timeout_flag, bus.SRAM_address, idle_addr);
    end
    exp_q.push_back(exp_t'{2, 3'b001, 1'b0});
    Reset = 1'b0; Start = 1'b1;
    wait_en_change(10, n, to);
    Start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (to || n != e.lat || bus.Stage_enable !== e.en || Current_stage !== 3'd0) begin
      errors++; $display("FAIL restart_after_reset: to=%0d lat=%0d en=%b cur=%0d expected lat=%0d en=%b cur=0",
        to, n, bus.Stage_enable, Current_stage, e.lat, e.en);
    end
  endtask

  initial begin
    saddr[0] = 18'h10A00; saddr[1] = 18'h20B01; saddr[2] = 18'h30C02;
    sdata[0] = 16'hA0A0;  sdata[1] = 16'hB1B1;  sdata[2] = 16'hC2C2;
    bus.Stage_SRAM_address    = {saddr[2], saddr[1], saddr[0]};
    bus.Stage_SRAM_write_data = {sdata[2], sdata[1], sdata[0]};
    bus.Stage_SRAM_we_n       = SWE;
    test_reset();
    test_start_handoff();
    test_no_activity();
    test_timeout();
    test_stage_sequence();
    test_done_and_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
